snn_spike_rate_decoder: RTL

Output-side counterpart of the SNN input-setup path. The setup path shifts bytes into the network. This block decodes the output-layer spike trains back into bytes for the host.
- Counts spikes per output neuron over a programmable window of timesteps.
- Snapshots the counts at the end of each window and finds the winning neuron sequentially.
- Streams the frame (winner byte, then one count byte per neuron) over an 8-bit valid/ack byte port.
- Sits between the last LIF layer's is_spike vector and the output pins.

---
 rtl/snn_spike_rate_decoder_pkg.sv | 18 +
 rtl/snn_spike_rate_decoder_argmax_scan.sv | 36 +++
 rtl/snn_spike_rate_decoder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/snn_spike_rate_decoder_pkg.sv
// Shared types and constants for the SNN output spike-rate decoder.
package snn_decode_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SEND
  } state_t;

  localparam logic [7:0] NO_WINNER  = 8'hFF;
  localparam int         COUNT_BITS = 8;

  // Winner byte followed by one count byte per neuron
  function automatic int frame_len(input int neurons);
    return neurons + 1;
  endfunction

endpackage

// File: rtl/snn_spike_rate_decoder_argmax_scan.sv
// Sequential argmax over a snapshot, one count per step.
// Only a strictly greater count takes the lead, so the lowest index wins ties.
module argmax_scan
  import snn_decode_pkg::*;
#(
  parameter int NEURONS  = 8,
  parameter int IDX_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  step,
  input  logic [COUNT_BITS-1:0] cnt_in,
  input  logic [IDX_BITS-1:0]   idx,
  output logic [7:0]            best_idx,
  output logic                  done
);

  logic [COUNT_BITS-1:0] best_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_cnt <= '0;
      best_idx <= '0;
    end else if (start) begin
      best_cnt <= '0;
      best_idx <= NO_WINNER;
    end else if (step && (cnt_in > best_cnt)) begin
      best_cnt <= cnt_in;
      best_idx <= 8'(idx);
    end
  end

  assign done = step && (idx == IDX_BITS'(NEURONS - 1));

endmodule

// File: rtl/snn_spike_rate_decoder.sv
// Counts output-layer spikes per window, then streams winner + per-neuron counts
// to the host over an 8-bit valid/ack byte port.
module snn_spike_rate_decoder
  import snn_decode_pkg::*;
#(
  parameter int NEURONS     = 8,
  parameter int WINDOW_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NEURONS-1:0]     spikes,
  input  logic [WINDOW_BITS-1:0] window_len,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ack,
  output logic                   out_last,
  input  logic                   overrun_clr,
  output logic                   overrun,
  output logic                   busy
);

  localparam int IDX_BITS = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam int PTR_BITS = $clog2(NEURONS + 1);
  localparam logic [PTR_BITS-1:0] LAST_PTR = PTR_BITS'(frame_len(NEURONS) - 1);

  state_t state, state_next;

  logic [COUNT_BITS-1:0]  acc      [NEURONS];
  logic [COUNT_BITS-1:0]  snap     [NEURONS];
  logic [COUNT_BITS-1:0]  sum      [NEURONS];
  logic [COUNT_BITS:0]    sum_wide [NEURONS];
  logic [WINDOW_BITS-1:0] tstep;
  logic [WINDOW_BITS-1:0] last_step;
  logic [IDX_BITS-1:0]    scan_idx;
  logic [PTR_BITS-1:0]    byte_ptr;
  logic [COUNT_BITS-1:0]  scan_cnt;
  logic [7:0]             best_idx;
  logic                   scan_done;
  logic                   win_close;
  logic                   last_accept;
  logic                   capture;

  // Saturating per-neuron sum for the current step; also what a snapshot captures
  always_comb begin
    for (int i = 0; i < NEURONS; i++) begin
      sum_wide[i] = {1'b0, acc[i]} + {{COUNT_BITS{1'b0}}, spikes[i]};
      sum[i]      = sum_wide[i][COUNT_BITS] ? {COUNT_BITS{1'b1}} : sum_wide[i][COUNT_BITS-1:0];
    end
  end

  assign last_step   = (window_len == '0) ? '0 : window_len - 1'b1;
  assign win_close   = enable && (tstep >= last_step);
  assign last_accept = (state == SEND) && out_ack && (byte_ptr == LAST_PTR);
  assign capture     = win_close && ((state == IDLE) || last_accept);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tstep <= '0;
      for (int i = 0; i < NEURONS; i++) begin
        acc[i]  <= '0;
        snap[i] <= '0;
      end
    end else begin
      if (enable) begin
        tstep <= win_close ? '0 : tstep + 1'b1;
        for (int i = 0; i < NEURONS; i++) begin
          acc[i] <= win_close ? '0 : sum[i];
        end
      end
      if (capture) begin
        for (int i = 0; i < NEURONS; i++) begin
          snap[i] <= sum[i];
        end
      end
    end
  end

  // A window closing while a frame is still in flight loses its snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (win_close && !capture) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  always_comb begin
    scan_cnt = '0;
    for (int k = 0; k < NEURONS; k++) begin
      if (scan_idx == IDX_BITS'(k)) begin
        scan_cnt = snap[k];
      end
    end
  end

  argmax_scan #(
    .NEURONS  (NEURONS),
    .IDX_BITS (IDX_BITS)
  ) u_argmax (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (capture),
    .step     (state == SCAN),
    .cnt_in   (scan_cnt),
    .idx      (scan_idx),
    .best_idx (best_idx),
    .done     (scan_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (capture) state_next = SCAN;
      SCAN: if (scan_done) state_next = SEND;
      SEND: if (last_accept) state_next = capture ? SCAN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_idx <= '0;
      byte_ptr <= '0;
    end else begin
      if (capture) begin
        scan_idx <= '0;
      end else if ((state == SCAN) && !scan_done) begin
        scan_idx <= scan_idx + 1'b1;
      end
      if ((state == SCAN) && scan_done) begin
        byte_ptr <= '0;
      end else if (last_accept) begin
        byte_ptr <= '0;
      end else if ((state == SEND) && out_ack) begin
        byte_ptr <= byte_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    if (state == SEND) begin
      out_valid = 1'b1;
      out_last  = (byte_ptr == LAST_PTR);
      if (byte_ptr == '0) begin
        out_data = best_idx;
      end else begin
        for (int k = 0; k < NEURONS; k++) begin
          if (byte_ptr == PTR_BITS'(k + 1)) begin
            out_data = snap[k];
          end
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
